// File: rtl/adc_scan_ctrl_if.sv
// Bundle between the scan sequencer, the analog ADC macro and the register-side
// result reader.
//
// ADC side: adc_start is a one-cycle request; the macro answers later with a
// one-cycle adc_eoc carrying adc_dout. There is no back-pressure.
// Read side (valid/ready): rd_valid is the FIFO's "valid" and rd_en its "ready".
// A word moves on any rising clk edge where both are high. rd_data is stable
// while rd_valid=1 and is not popped. rd_en while rd_valid=0 has no effect.
interface adc_scan_ctrl_if #(
   parameter int NUM_CH     = 8,
   parameter int DW         = 10,
   parameter int FIFO_DEPTH = 8
);
   localparam int CHW = $clog2(NUM_CH);
   localparam int LW  = $clog2(FIFO_DEPTH) + 1;

   logic                 adc_start;
   logic [CHW-1:0]       adc_ch_sel;
   logic                 adc_eoc;
   logic [DW-1:0]        adc_dout;
   logic                 rd_en;
   logic                 rd_valid;
   logic [CHW+DW-1:0]    rd_data;
   logic [LW-1:0]        fifo_level;

   // The sequencer's view.
   modport master (
      output adc_start, adc_ch_sel, rd_valid, rd_data, fifo_level,
      input  adc_eoc, adc_dout, rd_en
   );

   // The ADC macro and the result reader, seen from outside.
   modport slave (
      input  adc_start, adc_ch_sel, rd_valid, rd_data, fifo_level,
      output adc_eoc, adc_dout, rd_en
   );
endinterface

// File: rtl/adc_scan_ctrl.sv
// Multi-channel SAR-ADC scan sequencer. It walks a latched channel mask and
// optionally averages 2^k conversions per channel. It pushes {channel, result}
// words into a FWFT result FIFO.
module adc_scan_ctrl #(
   parameter int NUM_CH      = 8,
   parameter int DW          = 10,
   parameter int AVG_MAX     = 3,
   parameter int FIFO_DEPTH  = 8,
   parameter int TIMEOUT_CYC = 255,
   parameter int CHW         = $clog2(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_en,
   input  logic              cfg_mode,
   input  logic [NUM_CH-1:0] cfg_ch_mask,
   input  logic [2:0]        cfg_avg_log2,
   input  logic [7:0]        cfg_settle,
   input  logic              trig,
   input  logic              err_clr,
   output logic              busy,
   output logic              ovf,
   output logic              tmo,
   output logic [2:0]        dbg_state,
   adc_scan_ctrl_if.master   bus
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int LW   = AW + 1;
   localparam int ACW  = DW + AVG_MAX;
   localparam int SCW  = AVG_MAX + 1;
   localparam int CNTW = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETTLE = 3'd1,
      S_START  = 3'd2,
      S_WAIT   = 3'd3,
      S_ACCUM  = 3'd4,
      S_PUSH   = 3'd5
   } state_t;

   state_t            state, state_nx;
   logic [NUM_CH-1:0] mask_q;
   logic              mode_q;
   logic [2:0]        avg_q;
   logic [7:0]        settle_q;
   logic [CHW-1:0]    ch_q;
   logic [CNTW-1:0]   cnt;
   logic [SCW-1:0]    nsmp;
   logic [ACW-1:0]    acc;
   logic [DW-1:0]     smp_q;
   logic              en_d;

   logic [CHW-1:0]    cfg_first;
   logic [CHW-1:0]    nxt_ch;
   logic              nxt_found;
   logic [2:0]        avg_clamp;
   logic              start_scan;
   logic              scan_load;
   logic              tmo_hit;
   logic              acc_last;
   logic [DW-1:0]     res;

   logic [CHW+DW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wp, rp;
   logic [LW-1:0]     level;
   logic              full, pop, push_req, push_ok, ovf_set;

   assign avg_clamp  = (cfg_avg_log2 > 3'(AVG_MAX)) ? 3'(AVG_MAX) : cfg_avg_log2;
   // A scan starts on trig, or in continuous mode on the rising edge of cfg_en.
   assign start_scan = cfg_en && (cfg_ch_mask != '0) && (trig || (cfg_mode && !en_d));
   // Config is sampled at scan start and again when a continuous scan wraps.
   assign scan_load  = (state == S_IDLE && start_scan) ||
                       (state == S_PUSH && !nxt_found && mode_q && (cfg_ch_mask != '0));
   assign tmo_hit    = (state == S_WAIT) && !bus.adc_eoc && (cnt == CNTW'(TIMEOUT_CYC - 1));
   assign acc_last   = (nsmp + SCW'(1)) == (SCW'(1) << avg_q);
   assign res        = DW'(acc >> avg_q);

   // Lowest enabled channel of the live config mask (entry point of a scan).
   always_comb begin
      cfg_first = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (cfg_ch_mask[i]) cfg_first = CHW'(i);
   end

   // Next enabled channel above the current one in the latched mask.
   always_comb begin
      nxt_ch    = '0;
      nxt_found = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (mask_q[i] && (i > int'(ch_q))) begin
            nxt_ch    = CHW'(i);
            nxt_found = 1'b1;
         end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic. Dropping cfg_en overrides every transition.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start_scan) state_nx = S_SETTLE;
         S_SETTLE: if (cnt == CNTW'(settle_q)) state_nx = S_START;
         S_START:  state_nx = S_WAIT;
         S_WAIT:   if (bus.adc_eoc) state_nx = S_ACCUM;
                   else if (tmo_hit) state_nx = S_IDLE;
         S_ACCUM:  state_nx = acc_last ? S_PUSH : S_START;
         S_PUSH:   if (nxt_found || scan_load) state_nx = S_SETTLE;
                   else state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
      if (!cfg_en) state_nx = S_IDLE;
   end

   // Scan datapath: config latch, channel pointer, cycle counter, accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q   <= '0;
         mode_q   <= 1'b0;
         avg_q    <= '0;
         settle_q <= '0;
         ch_q     <= '0;
         cnt      <= '0;
         nsmp     <= '0;
         acc      <= '0;
         smp_q    <= '0;
         en_d     <= 1'b0;
      end else begin
         en_d <= cfg_en;
         if (scan_load) begin
            mask_q   <= cfg_ch_mask;
            mode_q   <= cfg_mode;
            avg_q    <= avg_clamp;
            settle_q <= cfg_settle;
            ch_q     <= cfg_first;
         end else if (state == S_PUSH && nxt_found) begin
            ch_q <= nxt_ch;
         end
         case (state)
            S_SETTLE: cnt <= cnt + CNTW'(1);
            S_START:  cnt <= CNTW'(1);
            S_WAIT: begin
               cnt <= cnt + CNTW'(1);
               if (bus.adc_eoc) smp_q <= bus.adc_dout;
            end
            S_ACCUM: begin
               acc  <= acc + ACW'(smp_q);
               nsmp <= nsmp + SCW'(1);
            end
            S_PUSH: begin
               acc  <= '0;
               nsmp <= '0;
               cnt  <= '0;
            end
            default: ;
         endcase
         // Abort, timeout and a fresh scan all discard any partial average.
         if (!cfg_en || tmo_hit || scan_load) begin
            acc  <= '0;
            nsmp <= '0;
            cnt  <= '0;
         end
      end
   end

   // FIFO control. A push into a full FIFO still lands when the same cycle pops.
   // An abort in PUSH wins, so nothing is written after cfg_en falls.
   assign push_req = (state == S_PUSH) && cfg_en;
   assign full     = (level == LW'(FIFO_DEPTH));
   assign pop      = bus.rd_en && (level != '0);
   assign push_ok  = push_req && (!full || bus.rd_en);
   assign ovf_set  = push_req && full && !bus.rd_en;

   // Result storage, no reset needed.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wp] <= {ch_q, res};
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         level <= '0;
      end else begin
         if (push_ok) wp <= wp + AW'(1);
         if (pop)     rp <= rp + AW'(1);
         level <= level + LW'(push_ok) - LW'(pop);
      end
   end

   // Sticky error flags; a new event wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
         tmo <= 1'b0;
      end else begin
         if (ovf_set)      ovf <= 1'b1;
         else if (err_clr) ovf <= 1'b0;
         if (tmo_hit)      tmo <= 1'b1;
         else if (err_clr) tmo <= 1'b0;
      end
   end

   assign bus.adc_start  = (state == S_START) && cfg_en;
   assign bus.adc_ch_sel = ch_q;
   assign bus.rd_valid   = (level != '0);
   assign bus.rd_data    = mem[rp];
   assign bus.fifo_level = level;
   assign busy           = (state != S_IDLE);
   assign dbg_state      = state;
endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl with a behavioural ADC macro model.
`timescale 1ns/1ps
module tb_adc_scan_ctrl;
   localparam int NUM_CH      = 8;
   localparam int DW          = 10;
   localparam int AVG_MAX     = 3;
   localparam int FIFO_DEPTH  = 8;
   localparam int TIMEOUT_CYC = 255;
   localparam int CHW         = $clog2(NUM_CH);
   localparam int RW          = CHW + DW;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SETTLE = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd3;
   localparam logic [2:0] ST_ACCUM  = 3'd4;
   localparam logic [2:0] ST_PUSH   = 3'd5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic              cfg_en, cfg_mode, trig, err_clr;
   logic [NUM_CH-1:0] cfg_ch_mask;
   logic [2:0]        cfg_avg_log2;
   logic [7:0]        cfg_settle;
   logic              busy, ovf, tmo;
   logic [2:0]        dbg_state;

   adc_scan_ctrl_if #(.NUM_CH(NUM_CH), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

   adc_scan_ctrl #(
      .NUM_CH(NUM_CH), .DW(DW), .AVG_MAX(AVG_MAX),
      .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_mode(cfg_mode),
      .cfg_ch_mask(cfg_ch_mask), .cfg_avg_log2(cfg_avg_log2),
      .cfg_settle(cfg_settle), .trig(trig), .err_clr(err_clr),
      .busy(busy), .ovf(ovf), .tmo(tmo), .dbg_state(dbg_state), .bus(bus)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [RW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- ADC macro model ----------------
   int   eoc_dly     = 1;
   bit   model_resp  = 1'b1;
   bit   model_sel   = 1'b0;
   int   samp_base   = 0;
   int   n_starts    = 0;
   int   n_settles   = 0;
   int   n_eoc       = 0;
   logic [DW-1:0] samp_tab [4] = '{10'd10, 10'd11, 10'd12, 10'd14};

   initial begin : adc_model
      int pend;
      logic [2:0] prev_st;
      pend = 0;
      prev_st = ST_IDLE;
      bus.adc_eoc  = 1'b0;
      bus.adc_dout = '0;
      forever begin
         @(negedge clk);
         bus.adc_eoc = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0 && model_resp) begin
               bus.adc_eoc = 1'b1;
               if (model_sel) bus.adc_dout = samp_tab[(n_eoc - samp_base) % 4];
               else           bus.adc_dout = 10'h100 + DW'(bus.adc_ch_sel);
               n_eoc++;
            end
         end
         if (bus.adc_start) begin
            n_starts++;
            pend = eoc_dly;
         end
         if (dbg_state == ST_SETTLE && prev_st != ST_SETTLE) n_settles++;
         prev_st = dbg_state;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_trig();
      trig = 1'b1;
      tick();
      trig = 1'b0;
   endtask

   task automatic wait_state(input string tag, input logic [2:0] st,
                             input logic [CHW-1:0] ch, input bit use_ch);
      int k;
      k = 0;
      while (!(dbg_state == st && (!use_ch || bus.adc_ch_sel == ch)) && k < 2000) begin
         tick();
         k++;
      end
      check(tag, 32'(k < 2000), 32'd1);
   endtask

   // Runs until busy drops; reports elapsed cycles, first cycle rd_valid was
   // seen and the state observed just before idle.
   task automatic wait_idle(output int cyc, output int fv, output logic [2:0] last_st);
      cyc = 0;
      fv = -1;
      last_st = dbg_state;
      while (cyc < 3000) begin
         if (bus.rd_valid && fv < 0) fv = cyc;
         if (!busy) break;
         last_st = dbg_state;
         tick();
         cyc++;
      end
      check("wait_idle bound", 32'(cyc < 3000), 32'd1);
   endtask

   task automatic drain();
      logic [RW-1:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("drain valid", 32'(bus.rd_valid), 32'd1);
         check("drain data", 32'(bus.rd_data), 32'(e));
         bus.rd_en = 1'b1;
         tick();
         bus.rd_en = 1'b0;
      end
      check("drain empty", 32'(bus.rd_valid), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " adc_start"},  32'(bus.adc_start),  32'd0);
      check({tag, " adc_ch_sel"}, 32'(bus.adc_ch_sel), 32'd0);
      check({tag, " rd_valid"},   32'(bus.rd_valid),   32'd0);
      check({tag, " fifo_level"}, 32'(bus.fifo_level), 32'd0);
      check({tag, " busy"},       32'(busy),           32'd0);
      check({tag, " ovf"},        32'(ovf),            32'd0);
      check({tag, " tmo"},        32'(tmo),            32'd0);
      check({tag, " state"},      32'(dbg_state),      32'(ST_IDLE));
   endtask

   // ---------------- directed sequence ----------------
   int cyc, fv, s0, st0, k;
   logic [2:0] last_st;

   initial begin : main
      cfg_en = 1'b0; cfg_mode = 1'b0; cfg_ch_mask = '0; cfg_avg_log2 = '0;
      cfg_settle = '0; trig = 1'b0; err_clr = 1'b0; bus.rd_en = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // trig with an empty mask is ignored
      cfg_en = 1'b1;
      pulse_trig();
      tick();
      check("zero mask busy", 32'(busy), 32'd0);

      // single scan over channels 0,2,7; mask change mid-scan must not matter
      cfg_ch_mask = 8'b1000_0101;
      s0 = n_starts;
      pulse_trig();
      check("scan settle", 32'(dbg_state), 32'(ST_SETTLE));
      cfg_ch_mask = 8'hFF;
      wait_idle(cyc, fv, last_st);
      check("scan cycles", 32'(cyc), 32'd15);
      check("scan first valid", 32'(fv), 32'd5);
      check("scan last state", 32'(last_st), 32'(ST_PUSH));
      check("scan starts", 32'(n_starts - s0), 32'd3);
      check("scan level", 32'(bus.fifo_level), 32'd3);
      check("scan ch hold", 32'(bus.adc_ch_sel), 32'd7);
      exp_q.push_back({3'd0, 10'h100});
      exp_q.push_back({3'd2, 10'h102});
      exp_q.push_back({3'd7, 10'h107});
      drain();

      // averaging of 4 samples: 10+11+12+14 = 47, 47>>2 = 11
      cfg_ch_mask = 8'h02; cfg_avg_log2 = 3'd2;
      model_sel = 1'b1; samp_base = n_eoc;
      s0 = n_starts; st0 = n_settles;
      pulse_trig();
      wait_idle(cyc, fv, last_st);
      check("avg4 cycles", 32'(cyc), 32'd14);
      check("avg4 starts", 32'(n_starts - s0), 32'd4);
      check("avg4 settles", 32'(n_settles - st0), 32'd1);
      exp_q.push_back({3'd1, 10'd11});
      drain();

      // avg=7 clamps to 3 -> 8 conversions
      model_sel = 1'b0; cfg_avg_log2 = 3'd7;
      s0 = n_starts;
      pulse_trig();
      wait_idle(cyc, fv, last_st);
      check("avg clamp cycles", 32'(cyc), 32'd26);
      check("avg clamp starts", 32'(n_starts - s0), 32'd8);
      exp_q.push_back({3'd1, 10'h101});
      drain();

      // settle=2 stretches SETTLE to 3 cycles
      cfg_avg_log2 = 3'd0; cfg_settle = 8'd2; cfg_ch_mask = 8'h01;
      pulse_trig();
      wait_idle(cyc, fv, last_st);
      check("settle cycles", 32'(cyc), 32'd7);
      exp_q.push_back({3'd0, 10'h100});
      drain();
      cfg_settle = 8'd0;

      // overflow in continuous mode, auto-start on cfg_en rise
      cfg_en = 1'b0;
      tick();
      cfg_mode = 1'b1; cfg_en = 1'b1;
      tick();
      check("cont autostart", 32'(dbg_state), 32'(ST_SETTLE));
      k = 0;
      while (bus.fifo_level != 4'd8 && k < 200) begin tick(); k++; end
      check("ovf fill bound", 32'(k < 200), 32'd1);
      check("ovf before 9th", 32'(ovf), 32'd0);
      wait_state("ovf 9th push", ST_PUSH, 3'd0, 1'b0);
      tick();
      check("ovf set", 32'(ovf), 32'd1);
      check("ovf level", 32'(bus.fifo_level), 32'd8);
      wait_state("ovf settle", ST_SETTLE, 3'd0, 1'b0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("ovf clear", 32'(ovf), 32'd0);
      wait_state("ovf push2", ST_PUSH, 3'd0, 1'b0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("ovf set beats clr", 32'(ovf), 32'd1);
      wait_state("ovf push3", ST_PUSH, 3'd0, 1'b0);
      bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
      check("full rd+push level", 32'(bus.fifo_level), 32'd8);
      cfg_en = 1'b0;
      tick();
      check("cont stop busy", 32'(busy), 32'd0);
      cfg_mode = 1'b0; cfg_en = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) exp_q.push_back({3'd0, 10'h100});
      drain();
      err_clr = 1'b1; tick(); err_clr = 1'b0;

      // timeout: ADC never answers
      model_resp = 1'b0;
      pulse_trig();
      k = 0;
      while (!bus.adc_start && k < 50) begin tick(); k++; end
      check("tmo start seen", 32'(bus.adc_start), 32'd1);
      k = 0;
      while (!tmo && k < 400) begin tick(); k++; end
      check("tmo latency", 32'(k), 32'(TIMEOUT_CYC));
      check("tmo state", 32'(dbg_state), 32'(ST_IDLE));
      check("tmo no write", 32'(bus.fifo_level), 32'd0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("tmo clear", 32'(tmo), 32'd0);
      model_resp = 1'b1;

      // abort during WAIT_EOC of channel 3
      eoc_dly = 5;
      cfg_ch_mask = 8'b0000_1011;
      pulse_trig();
      wait_state("abort wait ch3", ST_WAIT, 3'd3, 1'b1);
      cfg_en = 1'b0;
      tick();
      check("abort state", 32'(dbg_state), 32'(ST_IDLE));
      check("abort start", 32'(bus.adc_start), 32'd0);
      cfg_en = 1'b1;
      repeat (8) tick();
      check("abort level", 32'(bus.fifo_level), 32'd2);
      check("abort busy", 32'(busy), 32'd0);
      exp_q.push_back({3'd0, 10'h100});
      exp_q.push_back({3'd1, 10'h101});
      drain();
      eoc_dly = 1;

      // reset during ACCUM of channel 2
      cfg_ch_mask = 8'h05;
      pulse_trig();
      wait_state("rst accum ch2", ST_ACCUM, 3'd2, 1'b1);
      check("rst pre level", 32'(bus.fifo_level), 32'd1);
      rst = 1'b1;
      tick();
      check_reset_outputs("midrst");
      rst = 1'b0;
      tick();
      check("post rst busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/adc_scan_ctrl.md
Name: adc_scan_ctrl

Overview:
- Parametrised multi-channel SAR-ADC scan sequencer, successor to the single-channel ADC hookup in the analog top.
- Walks an enabled-channel mask and drives start/channel-select to the analog ADC macro.
- Optionally averages 2^k samples per channel.
- Writes channel-tagged results into a first-word-fall-through (FWFT) result FIFO read by the APB register block.

Parameters:
- NUM_CH, 8, number of analog input channels (2..16).
- DW, 10, ADC result width.
- AVG_MAX, 3, maximum log2 of samples averaged.
- FIFO_DEPTH, 8, result FIFO entries (power of 2).
- TIMEOUT_CYC, 255, maximum cycles waiting for end-of-conversion.
- CHW, $clog2(NUM_CH), derived channel index width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cfg_en  in  1  block enable; low aborts any scan
- cfg_mode  in  1  0 = single pass per trig, 1 = continuous scan
- cfg_ch_mask  in  NUM_CH  channel enable mask
- cfg_avg_log2  in  3  log2 of samples averaged per channel
- cfg_settle  in  8  mux settle cycles before first start
- trig  in  1  scan start pulse
- adc_start  out  1  one-cycle conversion start to ADC macro
- adc_ch_sel  out  CHW  analog mux select
- adc_eoc  in  1  end of conversion, already synchronous to clk
- adc_dout  in  DW  conversion result, valid when adc_eoc=1
- rd_en  in  1  FIFO pop
- rd_valid  out  1  FIFO not empty
- rd_data  out  CHW+DW  {channel, result}, FWFT
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy
- busy  out  1  FSM not IDLE
- ovf  out  1  sticky FIFO overflow
- tmo  out  1  sticky EOC timeout
- err_clr  in  1  clears ovf and tmo

Behaviour:
- Reset values: adc_start=0, adc_ch_sel=0, rd_valid=0, fifo_level=0, busy=0, ovf=0, tmo=0. FSM=IDLE, FIFO empty, accumulator=0.
- FSM states: IDLE, SETTLE, START, WAIT_EOC, ACCUM, PUSH.
- IDLE -> SETTLE on cycle after trig=1 when cfg_en=1 and cfg_ch_mask!=0.
  - In continuous mode, also on cycle after cfg_en rises with a nonzero mask; no trig needed.
  - trig ignored when busy or mask=0.
- Scan start latches mask, mode, avg and settle; config changes mid-scan take effect on the next scan.
  - Continuous wrap relatches.
  - Latched avg > AVG_MAX clamps to AVG_MAX.
- Channel order: ascending index of set mask bits; zero bits skipped with no cycle cost.
- SETTLE: adc_ch_sel = current channel; lasts latched settle+1 cycles; then START.
- START: adc_start=1 for exactly one cycle; then WAIT_EOC.
- WAIT_EOC:
  - adc_eoc sampled only in this state; eoc in other states is ignored.
  - On eoc=1, capture adc_dout and go to ACCUM.
  - Counter reaching TIMEOUT_CYC without eoc: set tmo, discard the channel's accumulation, go to IDLE (scan abandoned, both modes).
- ACCUM:
  - acc += sample; acc width DW+AVG_MAX, no overflow possible.
  - If samples taken < 2^avg, go to START (no re-settle); else go to PUSH.
- PUSH:
  - result = acc >> avg (truncating); write {ch, result}; clear acc.
  - Next enabled channel -> SETTLE.
  - After the last channel: single mode -> IDLE; continuous -> lowest enabled channel -> SETTLE.
- adc_ch_sel stays stable from SETTLE through PUSH and holds its last value in IDLE.
- cfg_en=0 in any state: next cycle IDLE, adc_start=0, partial accumulation discarded, FIFO contents kept.
- FIFO:
  - FWFT: rd_data is valid whenever rd_valid=1; rd_en with rd_valid=0 is ignored.
  - Push is accepted if not full, or if full with rd_en=1 the same cycle (pop and push together, level unchanged).
  - Push when full and rd_en=0: new result dropped, ovf set.
- ovf and tmo: set has priority over err_clr in the same cycle.
- Minimum per-channel latency with avg=0, settle=0, eoc one cycle after start: SETTLE 1 + START 1 + WAIT 1 + ACCUM 1 + PUSH 1 = 5 cycles. rd_valid rises the cycle after PUSH.

Test Plan:
- Single scan: mask=8'b1000_0101, avg=0, settle=0, model returns 10'h100+ch. Required:
  - FIFO holds {0,0x100}, {2,0x102}, {7,0x107} in that order.
  - 3 adc_start pulses.
  - busy falls after the last PUSH.
- Averaging: mask=0x02, avg=2, samples 10,11,12,14 -> one entry {1,11} (47>>2). Exactly 4 starts; one SETTLE only. avg=7 behaves as avg=3 (8 starts).
- Overflow: FIFO_DEPTH=8, continuous mode, mask=0x01, no reads. Required:
  - After 8 pushes the 9th result is dropped and ovf=1.
  - err_clr with a simultaneous new overflow leaves ovf=1.
  - A later read+push while full keeps level at 8.
- Timeout: model never asserts eoc. Required: tmo=1 exactly TIMEOUT_CYC cycles after START; FSM returns to IDLE; no FIFO write.
- Abort: cfg_en=0 during WAIT_EOC of channel 3. Required: IDLE next cycle; later eoc ignored; no write for channel 3; earlier entries remain readable.
- Reset mid-scan: rst=1 during ACCUM. Required: all outputs at reset values the next cycle; FIFO empty.
